// File: rtl/tagged_pipe_elastic.sv
// tagged_pipe_elastic
// Elastic pipeline of tagged records. A command (2-bit tag + payload) enters
// stage 0 through a valid/ready handshake, moves toward the tail whenever the
// next slot is free or being vacated, and is delivered at the tail through a
// second valid/ready handshake. DATA records gain INCR on every
// stage-to-stage advance; HOLD records pass through unchanged. FLUSH clears
// every stage; NOP is consumed and does nothing.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. ready never depends on valid. Once the tail offers a record it
// keeps __out0/__out_valid stable until the record is taken.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   __in0        command {tag[1:0], payload[DATA_W-1:0]}
//                tag 0 LOAD, 1 HOLD, 2 FLUSH, 3 NOP
//   __in_valid   command present
//   __in_ready   command accepted this cycle if __in_valid is also high
//   __out0       tail record {kind, value}, kind 0 = DATA, 1 = HOLD; 0 when empty
//   __out_valid  tail stage holds a record
//   __out_ready  downstream accepts the tail record
//   __count      delivered records, modulo 2^16
module tagged_pipe_elastic #(
  parameter int          DATA_W = 8,
  parameter int          DEPTH  = 2,
  parameter int unsigned INCR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] __in0,
  input  logic              __in_valid,
  output logic              __in_ready,
  output logic [DATA_W:0]   __out0,
  output logic              __out_valid,
  input  logic              __out_ready,
  output logic [15:0]       __count
);

  localparam logic [1:0] TAG_LOAD  = 2'd0;
  localparam logic [1:0] TAG_HOLD  = 2'd1;
  localparam logic [1:0] TAG_FLUSH = 2'd2;

  localparam logic [DATA_W-1:0] INC = DATA_W'(INCR);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  kind;
  logic [DATA_W-1:0] value [DEPTH];
  logic [DEPTH-1:0]  move;
  logic [15:0]       count;

  logic       chain;
  logic [1:0] tag;
  logic       accept;
  logic       inject;
  logic       flush;

  // Move chain, tail first. A stage moves when it is valid and the slot in
  // front of it is either empty (bubble collapse) or itself moving. chain
  // carries the downstream stage's move decision to the next iteration.
  always_comb begin
    move  = '0;
    chain = v[DEPTH-1] & __out_ready;
    move[DEPTH-1] = chain;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      chain   = v[k] & (!v[k+1] | chain);
      move[k] = chain;
    end
  end

  assign tag        = __in0[DATA_W+1:DATA_W];
  assign __in_ready = !rst & (!v[0] | move[0]);
  assign accept     = __in_valid & __in_ready;
  assign inject     = accept & ((tag == TAG_LOAD) | (tag == TAG_HOLD));
  assign flush      = accept & (tag == TAG_FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      kind  <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) value[k] <= '0;
    end else begin
      // The tail handshake is counted even when a FLUSH lands on the same edge.
      if (__out_valid & __out_ready) count <= count + 16'd1;

      if (flush) begin
        // Advances computed this cycle are discarded.
        v    <= '0;
        kind <= '0;
        for (int k = 0; k < DEPTH; k++) value[k] <= '0;
      end else begin
        for (int k = 1; k < DEPTH; k++) begin
          if (move[k-1]) begin
            v[k]     <= 1'b1;
            kind[k]  <= kind[k-1];
            value[k] <= kind[k-1] ? value[k-1] : value[k-1] + INC;
          end else if (move[k]) begin
            v[k] <= 1'b0;
          end
        end
        if (inject) begin
          v[0]     <= 1'b1;
          kind[0]  <= (tag == TAG_HOLD);
          value[0] <= __in0[DATA_W-1:0];
        end else if (move[0]) begin
          v[0] <= 1'b0;
        end
      end
    end
  end

  assign __out_valid = v[DEPTH-1];
  assign __out0      = v[DEPTH-1] ? {kind[DEPTH-1], value[DEPTH-1]} : '0;
  assign __count     = count;

endmodule

// File: tb/tb_tagged_pipe_elastic.sv
// Bench for tagged_pipe_elastic with DATA_W=8, DEPTH=3, INCR=1.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A monitor keeps the queue of records in flight and
// compares every delivered record against it.
module tb_tagged_pipe_elastic;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 3;
  localparam int INCR   = 1;
  localparam logic [DATA_W-1:0] GAIN = DATA_W'((DEPTH - 1) * INCR);

  logic              clk;
  logic              rst;
  logic [DATA_W+1:0] in0;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W:0]   out0;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       count;

  int total = 0;
  int bad   = 0;

  logic [DATA_W:0] exp_q[$];
  logic [15:0]     exp_count = 16'd0;

  tagged_pipe_elastic #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INCR(INCR)) dut (
    .clk         (clk),
    .rst         (rst),
    .__in0       (in0),
    .__in_valid  (in_valid),
    .__in_ready  (in_ready),
    .__out0      (out0),
    .__out_valid (out_valid),
    .__out_ready (out_ready),
    .__count     (count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [DATA_W:0] exp;
    if (rst) begin
      exp_q.delete();
      exp_count = 16'd0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got %h with nothing in flight", out0);
        end else if (out_ready) begin
          exp = exp_q.pop_front();
          total++;
          if (out0 !== exp) begin
            bad++;
            $display("FAIL out_record: got %h expected %h", out0, exp);
          end
          exp_count = exp_count + 16'd1;
        end else begin
          total++;
          if (out0 !== exp_q[0]) begin
            bad++;
            $display("FAIL stalled_record: got %h expected %h", out0, exp_q[0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        case (in0[DATA_W+1:DATA_W])
          2'd0: exp_q.push_back({1'b0, in0[DATA_W-1:0] + GAIN});
          2'd1: exp_q.push_back({1'b1, in0[DATA_W-1:0]});
          2'd2: exp_q.delete();
          default: ;
        endcase
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] tg, input logic [DATA_W-1:0] pl);
    int n = 0;
    in0 = {tg, pl};
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b expected 1 within 100 cycles", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain_timeout: left=%0d out_valid=%b expected 0/0", exp_q.size(), out_valid);
    end
    step();
    @(negedge clk);
    total++;
    if (count !== exp_count) begin
      bad++;
      $display("FAIL count_after_drain: got %0d expected %0d", count, exp_count);
    end
    step();
  endtask

  task automatic check_out(input string name, input logic ov, input logic [DATA_W:0] o);
    total++;
    if (out_valid !== ov || (ov && out0 !== o) || (!ov && out0 !== '0)) begin
      bad++;
      $display("FAIL %s: out_valid=%b out0=%h expected %b/%h", name, out_valid, out0, ov,
               ov ? o : '0);
    end
  endtask

  task automatic check_ready(input string name, input logic r);
    total++;
    if (in_ready !== r) begin
      bad++;
      $display("FAIL %s: in_ready=%b expected %b", name, in_ready, r);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in0 = '0; out_ready = 1'b0;
    step(); step();
    in_valid = 1'b1; in0 = {2'd0, 8'hAA};
    @(negedge clk);
    check_ready("reset_ready_low", 1'b0);
    check_out("reset_out", 1'b0, '0);
    total++;
    if (count !== 16'd0) begin
      bad++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_ready("ready_after_reset", 1'b1);
    check_out("out_after_reset", 1'b0, '0);
    step();
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(2'd0, 8'h10);
    @(negedge clk); check_out("latency_c1", 1'b0, '0);
    step(); @(negedge clk); check_out("latency_c2", 1'b0, '0);
    step(); @(negedge clk); check_out("latency_c3", 1'b1, {1'b0, 8'h12});
    step(); @(negedge clk);
    total++;
    if (count !== 16'd1) begin
      bad++; $display("FAIL latency_count: got %0d expected 1", count);
    end
    step();
  endtask

  task automatic test_hold_wrap();
    out_ready = 1'b1;
    send(2'd1, 8'h55);
    send(2'd0, 8'hFF);
    drain();
    total++;
    if (count !== 16'd3) begin
      bad++; $display("FAIL hold_wrap_count: got %0d expected 3", count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in0 = {2'd0, 8'(i)};
      @(negedge clk);
      check_ready("bp_accept", i < 4);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_ready("bp_full", 1'b0);
      check_out("bp_tail_stable", 1'b1, {1'b0, 8'h03});
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_ready("bp_ready_returns", 1'b1);
    step();
    in_valid = 1'b0;
    drain();
    total++;
    if (count !== 16'd7) begin
      bad++; $display("FAIL bp_count: got %0d expected 7", count);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    send(2'd0, 8'h20);
    send(2'd3, 8'h00);
    send(2'd0, 8'h30);
    @(negedge clk); check_out("bubble_c3", 1'b1, {1'b0, 8'h22});
    step();
    @(negedge clk);
    check_ready("bubble_ready", 1'b1);
    check_out("bubble_c4", 1'b1, {1'b0, 8'h22});
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk); check_out("bubble_adjacent", 1'b1, {1'b0, 8'h32});
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(2'd0, 8'h01);
    send(2'd1, 8'h02);
    send(2'd0, 8'h03);
    out_ready = 1'b1;
    in0 = {2'd2, 8'h00};
    in_valid = 1'b1;
    @(negedge clk);
    check_ready("flush_ready", 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check_out("flush_empty", 1'b0, '0);
    total++;
    if (count !== 16'd10) begin
      bad++; $display("FAIL flush_count: got %0d expected 10", count);
    end
    step();
    send(2'd0, 8'h40);
    @(negedge clk); check_out("post_flush_c1", 1'b0, '0);
    step(); @(negedge clk); check_out("post_flush_c2", 1'b0, '0);
    step(); @(negedge clk); check_out("post_flush_c3", 1'b1, {1'b0, 8'h42});
    drain();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      in0 = {(r == 0) ? 2'd2 : (r < 3) ? 2'd3 : (r < 9) ? 2'd1 : 2'd0,
             8'($urandom_range(0, 255))};
      step();
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(2'd0, 8'h70);
    send(2'd1, 8'h71);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_out("reset_mid_out", 1'b0, '0);
    total++;
    if (count !== 16'd0) begin
      bad++; $display("FAIL reset_mid_count: got %0d expected 0", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      check_out("no_stale", 1'b0, '0);
    end
    step();
  endtask

  task automatic test_count_wrap();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in0 = {2'd0, 8'($urandom_range(0, 255))};
      step();
    end
    in_valid = 1'b0;
    drain();
    total++;
    if (count !== 16'hFFFF) begin
      bad++; $display("FAIL count_ffff: got %h expected ffff", count);
    end
    send(2'd1, 8'h9C);
    drain();
    total++;
    if (count !== 16'h0000) begin
      bad++; $display("FAIL count_rollover: got %h expected 0000", count);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold_wrap();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    test_reset_mid();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
